// File: rtl/regmap_access_arbiter.sv
// Round-robin arbiter that shares the register-map access port between
// requester A (SPI side) and requester B (sequencer/host).
module regmap_access_arbiter #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CONFIG_REG = 96
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  a_req_i,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic                  a_gnt_o,
  output logic                  a_rvalid_o,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  output logic                  a_wr_err_o,

  input  logic                  b_req_i,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic                  b_gnt_o,
  output logic                  b_rvalid_o,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  output logic                  b_wr_err_o,

  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  write_en_o,
  output logic                  read_en_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // One extra bit so a limit equal to 2**ADDR_WIDTH still fits.
  localparam logic [ADDR_WIDTH:0] CfgLimit = (ADDR_WIDTH + 1)'(NUM_CONFIG_REG);

  state_e                state_q, state_d;
  logic                  owner_b_q, owner_b_d;
  logic                  last_b_q, last_b_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic                  pick_b;
  logic                  wr_allowed;

  assign wr_allowed = ({1'b0, addr_q} < CfgLimit);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    owner_b_d  = owner_b_q;
    last_b_d   = last_b_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    pick_b     = 1'b0;
    a_gnt_o    = 1'b0;
    b_gnt_o    = 1'b0;
    a_wr_err_o = 1'b0;
    b_wr_err_o = 1'b0;
    write_en_o = 1'b0;
    read_en_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (a_req_i || b_req_i) begin
          // B wins when alone, or on a tie when A was granted last.
          pick_b    = b_req_i && (!a_req_i || !last_b_q);
          owner_b_d = pick_b;
          last_b_d  = pick_b;
          we_d      = pick_b ? b_we_i    : a_we_i;
          addr_d    = pick_b ? b_addr_i  : a_addr_i;
          wdata_d   = pick_b ? b_wdata_i : a_wdata_i;
          state_d   = ACCESS;
        end
      end

      ACCESS: begin
        a_gnt_o = !owner_b_q;
        b_gnt_o = owner_b_q;
        if (we_q) begin
          if (wr_allowed) begin
            write_en_o = 1'b1;
          end else begin
            a_wr_err_o = !owner_b_q;
            b_wr_err_o = owner_b_q;
          end
          state_d = IDLE;
        end else begin
          read_en_o = 1'b1;
          state_d   = RESP;
        end
      end

      RESP: begin
        if (owner_b_q) begin
          b_rdata_d  = read_data_i;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = read_data_i;
          a_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the read-data holding registers are reset along with the
      // control state, because both rdata outputs must read 0 after reset.
      state_q    <= IDLE;
      owner_b_q  <= 1'b0;
      last_b_q   <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      owner_b_q  <= owner_b_d;
      last_b_q   <= last_b_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  assign addr_o       = addr_q;
  assign write_data_o = wdata_q;
  assign a_rdata_o    = a_rdata_q;
  assign b_rdata_o    = b_rdata_q;
  assign a_rvalid_o   = a_rvalid_q;
  assign b_rvalid_o   = b_rvalid_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_regmap_access_arbiter.sv
// Directed bench for regmap_access_arbiter: a cycle-by-cycle vector table
// plus hand-written reset-mid-read and continuous-contention sequences.
module tb_regmap_access_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       a_req_i, a_we_i, b_req_i, b_we_i;
  logic [6:0] a_addr_i, b_addr_i;
  logic [7:0] a_wdata_i, b_wdata_i;
  logic       a_gnt_o, a_rvalid_o, a_wr_err_o;
  logic       b_gnt_o, b_rvalid_o, b_wr_err_o;
  logic [7:0] a_rdata_o, b_rdata_o;
  logic [6:0] addr_o;
  logic [7:0] write_data_o, read_data_i;
  logic       write_en_o, read_en_o, busy_o;

  always #5 clk_i = ~clk_i;

  regmap_access_arbiter #(
    .ADDR_WIDTH(7), .DATA_WIDTH(8), .NUM_CONFIG_REG(96)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
    .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o), .a_wr_err_o(a_wr_err_o),
    .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o), .b_wr_err_o(b_wr_err_o),
    .addr_o(addr_o), .write_data_o(write_data_o), .write_en_o(write_en_o),
    .read_en_o(read_en_o), .read_data_i(read_data_i), .busy_o(busy_o)
  );

  // Packed view: {gnt a,b | we,re | err a,b | rvalid a,b | busy | addr | wdata | a_rdata | b_rdata}
  logic [39:0] outs;
  assign outs = {a_gnt_o, b_gnt_o, write_en_o, read_en_o, a_wr_err_o, b_wr_err_o,
                 a_rvalid_o, b_rvalid_o, busy_o, addr_o, write_data_o, a_rdata_o, b_rdata_o};

  // Requester fields packed as {req, we, addr, wdata}.
  typedef struct {
    logic [16:0] a_in;
    logic [16:0] b_in;
    logic [7:0]  rd;
    logic [39:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  localparam logic [16:0] NONE = 17'h0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [16:0] a_in, input logic [16:0] b_in,
                     input logic [7:0] rd, input logic [39:0] exp);
    vec_t v;
    v.a_in = a_in; v.b_in = b_in; v.rd = rd; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [16:0] a_in, input logic [16:0] b_in, input logic [7:0] rd);
    {a_req_i, a_we_i, a_addr_i, a_wdata_i} = a_in;
    {b_req_i, b_we_i, b_addr_i, b_wdata_i} = b_in;
    read_data_i = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    byte who[$];
    int  when[$];

    rst_i = 1'b1;
    drive(NONE, NONE, 8'h00);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", outs, 40'h0);

    //  A inputs                      B inputs                      rd      gnt    en     err    rv     bsy  addr   wdata  a_rd   b_rd
    add({2'b11,7'h10,8'h5A},          NONE,                         8'h00, {2'b00,2'b00,2'b00,2'b00,1'b0,7'h00,8'h00,8'h00,8'h00}); // c0 A write
    add({2'b11,7'h10,8'h5A},          NONE,                         8'h00, {2'b10,2'b10,2'b00,2'b00,1'b1,7'h10,8'h5A,8'h00,8'h00}); // c1 ACCESS
    add(NONE,                         {2'b10,7'h70,8'h11},          8'h00, {2'b00,2'b00,2'b00,2'b00,1'b0,7'h10,8'h5A,8'h00,8'h00}); // c2 B read
    add(NONE,                         {2'b10,7'h70,8'h11},          8'h5E, {2'b01,2'b01,2'b00,2'b00,1'b1,7'h70,8'h11,8'h00,8'h00}); // c3 ACCESS
    add(NONE,                         NONE,                         8'hC3, {2'b00,2'b00,2'b00,2'b00,1'b1,7'h70,8'h11,8'h00,8'h00}); // c4 RESP
    add({2'b11,7'h60,8'hFF},          NONE,                         8'h00, {2'b00,2'b00,2'b00,2'b01,1'b0,7'h70,8'h11,8'h00,8'hC3}); // c5 rvalid B
    add({2'b11,7'h60,8'hFF},          NONE,                         8'h00, {2'b10,2'b00,2'b10,2'b00,1'b1,7'h60,8'hFF,8'h00,8'hC3}); // c6 blocked
    add({2'b11,7'h5F,8'h3C},          NONE,                         8'h00, {2'b00,2'b00,2'b00,2'b00,1'b0,7'h60,8'hFF,8'h00,8'hC3}); // c7 addr 95
    add({2'b11,7'h5F,8'h3C},          NONE,                         8'h00, {2'b10,2'b10,2'b00,2'b00,1'b1,7'h5F,8'h3C,8'h00,8'hC3}); // c8 accepted
    add({2'b10,7'h61,8'h00},          NONE,                         8'h00, {2'b00,2'b00,2'b00,2'b00,1'b0,7'h5F,8'h3C,8'h00,8'hC3}); // c9 A read
    add({2'b10,7'h61,8'h00},          NONE,                         8'h00, {2'b10,2'b01,2'b00,2'b00,1'b1,7'h61,8'h00,8'h00,8'hC3}); // c10
    add(NONE,                         NONE,                         8'h96, {2'b00,2'b00,2'b00,2'b00,1'b1,7'h61,8'h00,8'h00,8'hC3}); // c11 RESP
    add({2'b11,7'h05,8'hA5},          NONE,                         8'h00, {2'b00,2'b00,2'b00,2'b10,1'b0,7'h61,8'h00,8'h96,8'hC3}); // c12 b2b write
    add({2'b11,7'h05,8'hA5},          NONE,                         8'h00, {2'b10,2'b10,2'b00,2'b00,1'b1,7'h05,8'hA5,8'h96,8'hC3}); // c13
    add(NONE,                         NONE,                         8'h00, {2'b00,2'b00,2'b00,2'b00,1'b0,7'h05,8'hA5,8'h96,8'hC3}); // c14
    add(NONE,                         NONE,                         8'h00, {2'b00,2'b00,2'b00,2'b00,1'b0,7'h05,8'hA5,8'h96,8'hC3}); // c15 stays idle
    add({2'b11,7'h01,8'h01},          {2'b11,7'h02,8'h02},          8'h00, {2'b00,2'b00,2'b00,2'b00,1'b0,7'h05,8'hA5,8'h96,8'hC3}); // c16 tie
    add({2'b11,7'h01,8'h01},          {2'b11,7'h02,8'h02},          8'h00, {2'b01,2'b10,2'b00,2'b00,1'b1,7'h02,8'h02,8'h96,8'hC3}); // c17 B wins
    add({2'b11,7'h01,8'h01},          {2'b11,7'h02,8'h02},          8'h00, {2'b00,2'b00,2'b00,2'b00,1'b0,7'h02,8'h02,8'h96,8'hC3}); // c18 tie
    add({2'b11,7'h01,8'h01},          NONE,                         8'h00, {2'b10,2'b10,2'b00,2'b00,1'b1,7'h01,8'h01,8'h96,8'hC3}); // c19 A wins
    add(NONE,                         {2'b11,7'h7F,8'h77},          8'h00, {2'b00,2'b00,2'b00,2'b00,1'b0,7'h01,8'h01,8'h96,8'hC3}); // c20 B write 127
    add(NONE,                         {2'b11,7'h7F,8'h77},          8'h00, {2'b01,2'b00,2'b01,2'b00,1'b1,7'h7F,8'h77,8'h96,8'hC3}); // c21 blocked
    add(NONE,                         NONE,                         8'h00, {2'b00,2'b00,2'b00,2'b00,1'b0,7'h7F,8'h77,8'h96,8'hC3}); // c22

    foreach (tbl[i]) begin
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      drive(tbl[i].a_in, tbl[i].b_in, tbl[i].rd);
      @(negedge clk_i);
      check($sformatf("vec%0d", i), outs, tbl[i].exp);
    end

    // Reset during RESP of a B read: nothing from that read may surface.
    @(posedge clk_i); #1;
    drive(NONE, {2'b10,7'h20,8'h00}, 8'h00);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rst_read_access", {38'h0, b_gnt_o, read_en_o}, 40'h3);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    drive(NONE, NONE, 8'hEE);
    @(negedge clk_i);
    check("rst_read_in_resp", {39'h0, busy_o}, 40'h1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive({2'b11,7'h01,8'h01}, {2'b11,7'h02,8'h02}, 8'h00);
    @(negedge clk_i);
    check("rst_mid_read_outputs", outs, 40'h0);

    // Both ports request continuously from reset: expect A,B,A,B every 2 cycles.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      if (a_gnt_o && b_gnt_o) begin who.push_back("X"); when.push_back(c); end
      else if (a_gnt_o)       begin who.push_back("A"); when.push_back(c); end
      else if (b_gnt_o)       begin who.push_back("B"); when.push_back(c); end
    end
    for (int k = 0; k < 4; k++) begin
      byte exp_who;
      exp_who = (k % 2 == 0) ? "A" : "B";
      if (k < who.size())
        check($sformatf("contention_gnt%0d", k), {24'h0, who[k], 8'(when[k])},
              {24'h0, exp_who, 8'(2 * k)});
      else
        check($sformatf("contention_gnt%0d_missing", k), 40'h0, {24'h0, exp_who, 8'(2 * k)});
    end

    drive(NONE, NONE, 8'h00);
    repeat (3) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
